branch_predictor: RTL and testbench

Fetch-stage dynamic branch predictor for the RISC-V pipeline CPU, with a direct-mapped table of 2-bit saturating counters. It predicts direction and target for conditional branches (opcode 1100011) at IF. The EX-stage branch condition unit resolves each branch and returns the outcome, which trains the table. The block flags mispredictions and supplies the corrected PC to the PC mux, and keeps branch and mispredict statistics.

---
 rtl/branch_predictor_if.sv | 34 +++
 rtl/branch_predictor.sv | 87 ++++++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// Predictor <-> pipeline signal bundle.
//   master : pipeline side (drives IF/EX instruction info and EX outcome)
//   slave  : predictor side (drives prediction, redirect and statistics)
// Signals:
//   if_pc, if_inst          instruction currently in IF
//   pred_taken, pred_target prediction for the IF instruction
//   ex_valid, ex_pc, ex_inst, ex_branch, ex_pred_taken  resolved EX branch info
//   mispredict, redirect_pc EX misprediction flag and corrected next PC
//   branch_cnt, mispredict_cnt  running statistics
interface branch_predictor_if;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_inst;
  logic        ex_branch;
  logic        ex_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  modport master (
    output if_pc, if_inst, ex_valid, ex_pc, ex_inst, ex_branch, ex_pred_taken,
    input  pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );

  modport slave (
    input  if_pc, if_inst, ex_valid, ex_pc, ex_inst, ex_branch, ex_pred_taken,
    output pred_taken, pred_target, mispredict, redirect_pc, branch_cnt, mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Fetch-stage dynamic branch predictor: direct-mapped table of 2-bit
// saturating counters indexed by PC[IDX_BITS+1:2], trained by EX outcomes.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset (table -> CNT_INIT, stats -> 0)
//   bp    branch_predictor_if.slave (prediction, resolution, statistics)
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic               clk,
  input  logic               rst_n,
  branch_predictor_if.slave  bp
);
  localparam int unsigned DEPTH     = 1 << IDX_BITS;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;

  logic [1:0]          r_table [DEPTH];
  logic [31:0]         r_branch_cnt;
  logic [31:0]         r_mispredict_cnt;

  logic                w_if_is_br;
  logic [31:0]         w_if_imm;
  logic [IDX_BITS-1:0] w_if_idx;
  logic                w_ex_is_br;
  logic [31:0]         w_ex_imm;
  logic [IDX_BITS-1:0] w_ex_idx;
  logic                w_mispredict;
  logic [1:0]          w_ex_cnt;
  logic [1:0]          w_ex_cnt_next;
  logic                w_unused;

  // B-type immediate: {inst[31], inst[7], inst[30:25], inst[11:8], 0}, sign-extended
  assign w_if_is_br = (bp.if_inst[6:0] == OP_BRANCH);
  assign w_if_imm   = {{19{bp.if_inst[31]}}, bp.if_inst[31], bp.if_inst[7],
                       bp.if_inst[30:25], bp.if_inst[11:8], 1'b0};
  assign w_if_idx   = bp.if_pc[IDX_BITS+1:2];

  assign w_ex_is_br = bp.ex_valid && (bp.ex_inst[6:0] == OP_BRANCH);
  assign w_ex_imm   = {{19{bp.ex_inst[31]}}, bp.ex_inst[31], bp.ex_inst[7],
                       bp.ex_inst[30:25], bp.ex_inst[11:8], 1'b0};
  assign w_ex_idx   = bp.ex_pc[IDX_BITS+1:2];

  // Funct3/register fields play no part in prediction.
  assign w_unused = ^{bp.if_inst[24:12], bp.ex_inst[24:12]};

  // Prediction reads the registered table: a same-cycle training write is
  // not bypassed, so IF sees the pre-update counter.
  assign bp.pred_taken  = w_if_is_br && r_table[w_if_idx][1];
  assign bp.pred_target = bp.pred_taken ? (bp.if_pc + w_if_imm) : (bp.if_pc + 32'd4);

  assign w_mispredict   = w_ex_is_br && (bp.ex_branch ^ bp.ex_pred_taken);
  assign bp.mispredict  = w_mispredict;
  assign bp.redirect_pc = bp.ex_branch ? (bp.ex_pc + w_ex_imm) : (bp.ex_pc + 32'd4);

  assign bp.branch_cnt     = r_branch_cnt;
  assign bp.mispredict_cnt = r_mispredict_cnt;

  assign w_ex_cnt = r_table[w_ex_idx];

  always_comb begin
    w_ex_cnt_next = w_ex_cnt;
    if (bp.ex_branch) begin
      if (w_ex_cnt != 2'b11) w_ex_cnt_next = w_ex_cnt + 2'b01;
    end else begin
      if (w_ex_cnt != 2'b00) w_ex_cnt_next = w_ex_cnt - 2'b01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_table[i[IDX_BITS-1:0]] <= CNT_INIT;
      end
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (w_ex_is_br) begin
        r_table[w_ex_idx] <= w_ex_cnt_next;
        r_branch_cnt      <= r_branch_cnt + 32'd1;
      end
      if (w_mispredict) begin
        r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor.
// Stimulus is applied just after each falling edge and sampled 2 time units
// later; training takes effect at the following rising edge.
module tb_branch_predictor;
  localparam logic [31:0] BEQ_BACK = 32'hFE000CE3; // beq x0,x0,-8
  localparam logic [31:0] BEQ_FWD  = 32'h00000463; // beq x0,x0,+8
  localparam logic [31:0] ADDI     = 32'h00000013; // addi x0,x0,0

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_predictor_if bp ();

  branch_predictor #(.IDX_BITS(6), .CNT_INIT(2'b01)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bp    (bp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic br, input logic pt);
    @(negedge clk);
    bp.ex_valid = v; bp.ex_pc = pc; bp.ex_inst = inst;
    bp.ex_branch = br; bp.ex_pred_taken = pt;
    #2;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, ADDI, 1'b0, 1'b0);
  endtask

  task automatic set_if(input logic [31:0] pc, input logic [31:0] inst);
    bp.if_pc = pc; bp.if_inst = inst;
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bp.ex_valid = 1'b1; bp.ex_pc = 32'h4; bp.ex_inst = BEQ_BACK;
    bp.ex_branch = 1'b1; bp.ex_pred_taken = 1'b0;
    set_if(32'hFFFF_FFFC, BEQ_FWD);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_wrap_pred got=%b exp=0", bp.pred_taken); end
    checks++; if (bp.pred_target !== 32'h0) begin failures++; $display("FAIL reset_wrap_target got=%h exp=00000000", bp.pred_target); end
    checks++; if (bp.mispredict !== 1'b1) begin failures++; $display("FAIL reset_wrap_mp got=%b exp=1", bp.mispredict); end
    checks++; if (bp.redirect_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_wrap_redirect got=%h exp=fffffffc", bp.redirect_pc); end
    set_if(32'h100, BEQ_FWD);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL reset_pred got=%b exp=0", bp.pred_taken); end
    checks++; if (bp.pred_target !== 32'h104) begin failures++; $display("FAIL reset_target got=%h exp=00000104", bp.pred_target); end
    checks++; if (bp.branch_cnt !== 32'd0 || bp.mispredict_cnt !== 32'd0) begin failures++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", bp.branch_cnt, bp.mispredict_cnt); end
    @(negedge clk);
    bp.ex_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_train_loop();
    set_if(32'h200, BEQ_BACK);
    drive(1'b1, 32'h200, BEQ_BACK, 1'b1, 1'b0);
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL train_pred0 got=%b exp=0", bp.pred_taken); end
    checks++; if (bp.mispredict !== 1'b1) begin failures++; $display("FAIL train_mp0 got=%b exp=1", bp.mispredict); end
    checks++; if (bp.redirect_pc !== 32'h1F8) begin failures++; $display("FAIL train_redirect0 got=%h exp=000001f8", bp.redirect_pc); end
    drive(1'b1, 32'h200, BEQ_BACK, 1'b1, 1'b1);
    checks++; if (bp.mispredict !== 1'b0) begin failures++; $display("FAIL train_mp1 got=%b exp=0", bp.mispredict); end
    idle();
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL train_pred got=%b exp=1", bp.pred_taken); end
    checks++; if (bp.pred_target !== 32'h1F8) begin failures++; $display("FAIL train_target got=%h exp=000001f8", bp.pred_target); end
    checks++; if (bp.branch_cnt !== 32'd2 || bp.mispredict_cnt !== 32'd1) begin failures++; $display("FAIL train_counts got=%0d/%0d exp=2/1", bp.branch_cnt, bp.mispredict_cnt); end
  endtask

  task automatic test_saturation();
    set_if(32'h200, BEQ_BACK);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h200, BEQ_BACK, 1'b1, 1'b1);
      checks++; if (bp.mispredict !== 1'b0) begin failures++; $display("FAIL sat_up_mp[%0d] got=%b exp=0", i, bp.mispredict); end
    end
    drive(1'b1, 32'h200, BEQ_BACK, 1'b0, 1'b1);
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_top_pred got=%b exp=1", bp.pred_taken); end
    checks++; if (bp.mispredict !== 1'b1) begin failures++; $display("FAIL sat_nt_mp got=%b exp=1", bp.mispredict); end
    checks++; if (bp.redirect_pc !== 32'h204) begin failures++; $display("FAIL sat_nt_redirect got=%h exp=00000204", bp.redirect_pc); end
    idle();
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_weakT_pred got=%b exp=1", bp.pred_taken); end
    drive(1'b1, 32'h200, BEQ_BACK, 1'b0, 1'b1);
    idle();
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h204) begin failures++; $display("FAIL sat_weakNT got=%b/%h exp=0/00000204", bp.pred_taken, bp.pred_target); end
    drive(1'b1, 32'h200, BEQ_BACK, 1'b0, 1'b0);
    drive(1'b1, 32'h200, BEQ_BACK, 1'b0, 1'b0);
    drive(1'b1, 32'h200, BEQ_BACK, 1'b1, 1'b0);
    checks++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h1F8) begin failures++; $display("FAIL sat_bottom_mp got=%b/%h exp=1/000001f8", bp.mispredict, bp.redirect_pc); end
    idle();
    checks++; if (bp.pred_taken !== 1'b0) begin failures++; $display("FAIL sat_bottom_pred got=%b exp=0", bp.pred_taken); end
    drive(1'b1, 32'h200, BEQ_BACK, 1'b1, 1'b0);
    idle();
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL sat_recover_pred got=%b exp=1", bp.pred_taken); end
    checks++; if (bp.branch_cnt !== 32'd13 || bp.mispredict_cnt !== 32'd5) begin failures++; $display("FAIL sat_counts got=%0d/%0d exp=13/5", bp.branch_cnt, bp.mispredict_cnt); end
  endtask

  task automatic test_same_cycle_alias();
    pulse_reset();
    checks++; if (bp.branch_cnt !== 32'd0 || bp.mispredict_cnt !== 32'd0) begin failures++; $display("FAIL alias_reset_counts got=%0d/%0d exp=0/0", bp.branch_cnt, bp.mispredict_cnt); end
    set_if(32'h300, BEQ_FWD);
    drive(1'b1, 32'h300, BEQ_FWD, 1'b1, 1'b0);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h304) begin failures++; $display("FAIL same_cycle_pred got=%b/%h exp=0/00000304", bp.pred_taken, bp.pred_target); end
    checks++; if (bp.mispredict !== 1'b1 || bp.redirect_pc !== 32'h308) begin failures++; $display("FAIL same_cycle_mp got=%b/%h exp=1/00000308", bp.mispredict, bp.redirect_pc); end
    idle();
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h308) begin failures++; $display("FAIL next_cycle_pred got=%b/%h exp=1/00000308", bp.pred_taken, bp.pred_target); end
    set_if(32'h400, BEQ_FWD);
    checks++; if (bp.pred_taken !== 1'b1 || bp.pred_target !== 32'h408) begin failures++; $display("FAIL alias_pred got=%b/%h exp=1/00000408", bp.pred_taken, bp.pred_target); end
    set_if(32'h304, BEQ_FWD);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h308) begin failures++; $display("FAIL other_idx_pred got=%b/%h exp=0/00000308", bp.pred_taken, bp.pred_target); end
    set_if(32'h300, ADDI);
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h304) begin failures++; $display("FAIL nonbranch_pred got=%b/%h exp=0/00000304", bp.pred_taken, bp.pred_target); end
  endtask

  task automatic test_non_branch();
    set_if(32'h300, BEQ_FWD);
    drive(1'b1, 32'h300, ADDI, 1'b1, 1'b0);
    checks++; if (bp.mispredict !== 1'b0) begin failures++; $display("FAIL addi_mp got=%b exp=0", bp.mispredict); end
    drive(1'b1, 32'h300, ADDI, 1'b0, 1'b0);
    drive(1'b1, 32'h300, ADDI, 1'b0, 1'b0);
    drive(1'b0, 32'h300, BEQ_FWD, 1'b0, 1'b1);
    checks++; if (bp.mispredict !== 1'b0) begin failures++; $display("FAIL invalid_mp got=%b exp=0", bp.mispredict); end
    drive(1'b0, 32'h300, BEQ_FWD, 1'b0, 1'b1);
    idle();
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL nontrain_pred got=%b exp=1", bp.pred_taken); end
    checks++; if (bp.branch_cnt !== 32'd1 || bp.mispredict_cnt !== 32'd1) begin failures++; $display("FAIL nontrain_counts got=%0d/%0d exp=1/1", bp.branch_cnt, bp.mispredict_cnt); end
  endtask

  task automatic test_statistics_reset();
    pulse_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), BEQ_FWD, 1'b1, (i >= 3));
    end
    idle();
    checks++; if (bp.branch_cnt !== 32'd10) begin failures++; $display("FAIL stat_branch_cnt got=%0d exp=10", bp.branch_cnt); end
    checks++; if (bp.mispredict_cnt !== 32'd3) begin failures++; $display("FAIL stat_mispredict_cnt got=%0d exp=3", bp.mispredict_cnt); end
    set_if(32'h500, BEQ_FWD);
    checks++; if (bp.pred_taken !== 1'b1) begin failures++; $display("FAIL stat_trained_pred got=%b exp=1", bp.pred_taken); end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bp.branch_cnt !== 32'd0 || bp.mispredict_cnt !== 32'd0) begin failures++; $display("FAIL async_reset_counts got=%0d/%0d exp=0/0", bp.branch_cnt, bp.mispredict_cnt); end
    checks++; if (bp.pred_taken !== 1'b0 || bp.pred_target !== 32'h504) begin failures++; $display("FAIL async_reset_table got=%b/%h exp=0/00000504", bp.pred_taken, bp.pred_target); end
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bp.if_pc = '0; bp.if_inst = ADDI;
    bp.ex_valid = 1'b0; bp.ex_pc = '0; bp.ex_inst = ADDI;
    bp.ex_branch = 1'b0; bp.ex_pred_taken = 1'b0;
    test_reset();
    test_train_loop();
    test_saturation();
    test_same_cycle_alias();
    test_non_branch();
    test_statistics_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
